stopwatch_controller: RTL and testbench

- Sequences a stopwatch from the free-running 0.01 s pulse produced by the centisecond rate divider.
- Turns three user key levels (start/stop, lap, clear) into a run/pause/lap state machine.
- Maintains a BCD mm:ss.cc count and drives frozen (lap) or live values to the seven-segment display path.

---
 rtl/stopwatch_controller_pkg.sv | 29 ++
 rtl/stopwatch_controller_if.sv | 30 +++
 rtl/stopwatch_controller_bcd_mod_counter.sv | 41 ++++
 rtl/stopwatch_controller.sv | 184 ++++++++++++++++++
 tb/tb_stopwatch_controller.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_controller_pkg.sv
// Shared types and constants for the stopwatch controller slice.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents: FSM state encoding, BCD digit limits, and a helper that turns a
// small binary constant into its two-digit packed BCD form.
package stopwatch_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    // Highest value each sub-minute field reaches before rolling to 00.
    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;

    // Binary 0..99 to {tens, units} BCD; used to build compare constants.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Key, tick and display signals between the stopwatch and its surroundings.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a one-cycle pulse.
//
// master: drives tick and the three key levels, observes the display path.
// slave : the stopwatch itself (consumes keys/tick, drives display/status).
interface stopwatch_controller_if;

    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic       running;
    logic       lap_hold;
    logic       wrap;
    logic [7:0] disp_cs;
    logic [7:0] disp_sec;
    logic [7:0] disp_min;

    modport master (
        output tick, start_stop, lap, clear,
        input  running, lap_hold, wrap, disp_cs, disp_sec, disp_min
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output running, lap_hold, wrap, disp_cs, disp_sec, disp_min
    );

endinterface

// File: rtl/stopwatch_controller_bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MODULUS and then rolls to 00.
// Latency: value updates on the edge that samples inc; carry is combinational.
// Backpressure: none; inc is honoured every cycle it is high (clr wins).
//
// Ports: clock, resetn (sync, active-low), inc, clr -> value[7:0] {tens,units},
// carry (high in the cycle an inc rolls the count over, for same-cycle ripple).
module bcd_mod_counter
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned MODULUS = 99
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    localparam logic [7:0] MOD_BCD = to_bcd(MODULUS);

    // Carry is combinational so the next digit pair steps on the same edge.
    assign carry = inc & ~clr & (value == MOD_BCD);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            value <= 8'h00;
        end else if (clr) begin
            value <= 8'h00;
        end else if (inc) begin
            if (value == MOD_BCD) begin
                value <= 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value <= {value[7:4] + 4'd1, 4'd0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch: run/pause/lap FSM driving a BCD mm:ss.cc count to the display.
// Latency: state/status 1 cycle after a key press; display 1 cycle after count.
// Backpressure: none; keys are edge-detected levels, tick is a 1-cycle pulse.
//
// Ports: clock, resetn (sync, active-low), bus (slave modport): tick,
// start_stop, lap, clear in; running, lap_hold, wrap, disp_cs/sec/min out.
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic                    clock,
    input  logic                    resetn,
    stopwatch_controller_if.slave   bus
);

    state_t     state;

    logic       prev_ss;
    logic       prev_lap;
    logic       prev_clr;
    logic       press_ss;
    logic       press_lap;
    logic       press_clr;
    logic       ev_ss;
    logic       ev_lap;
    logic       ev_clr;

    logic       counting;
    logic       cs_inc;
    logic       count_clr;
    logic       cs_carry;
    logic       sec_carry;
    logic       min_carry;
    logic [7:0] cnt_cs;
    logic [7:0] cnt_sec;
    logic [7:0] cnt_min;

    logic [7:0] frz_cs;
    logic [7:0] frz_sec;
    logic [7:0] frz_min;

    logic       running_q;
    logic       lap_hold_q;
    logic       wrap_q;
    logic [7:0] disp_cs_q;
    logic [7:0] disp_sec_q;
    logic [7:0] disp_min_q;

    // Rising-edge detect. History resets to 1 so a key held through reset
    // must be released and pressed again before it counts.
    assign press_ss  = bus.start_stop & ~prev_ss;
    assign press_lap = bus.lap        & ~prev_lap;
    assign press_clr = bus.clear      & ~prev_clr;

    // One event per cycle: clear beats start_stop beats lap. A clear press
    // masks the others even in states where clear itself is ignored.
    assign ev_clr = press_clr;
    assign ev_ss  = press_ss  & ~press_clr;
    assign ev_lap = press_lap & ~press_clr & ~press_ss;

    // Counting looks at the pre-transition state: a tick alongside a start
    // press is lost, a tick alongside a stop press still lands.
    assign counting  = (state == RUN) || (state == LAP);
    assign cs_inc    = bus.tick & counting;
    assign count_clr = (state == PAUSED) & ev_clr;

    bcd_mod_counter #(.MODULUS(CS_MAX)) u_cs (
        .clock  (clock),
        .resetn (resetn),
        .inc    (cs_inc),
        .clr    (count_clr),
        .value  (cnt_cs),
        .carry  (cs_carry)
    );

    bcd_mod_counter #(.MODULUS(SEC_MAX)) u_sec (
        .clock  (clock),
        .resetn (resetn),
        .inc    (cs_carry),
        .clr    (count_clr),
        .value  (cnt_sec),
        .carry  (sec_carry)
    );

    bcd_mod_counter #(.MODULUS(MAX_MIN)) u_min (
        .clock  (clock),
        .resetn (resetn),
        .inc    (sec_carry),
        .clr    (count_clr),
        .value  (cnt_min),
        .carry  (min_carry)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            prev_ss    <= 1'b1;
            prev_lap   <= 1'b1;
            prev_clr   <= 1'b1;
            frz_cs     <= 8'h00;
            frz_sec    <= 8'h00;
            frz_min    <= 8'h00;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
            disp_cs_q  <= 8'h00;
            disp_sec_q <= 8'h00;
            disp_min_q <= 8'h00;
        end else begin
            prev_ss  <= bus.start_stop;
            prev_lap <= bus.lap;
            prev_clr <= bus.clear;

            // Min rolling over means the whole count just wrapped to zero.
            wrap_q <= min_carry;

            // Display trails the live count by one cycle; LAP shows the
            // snapshot instead.
            if (state == LAP) begin
                disp_cs_q  <= frz_cs;
                disp_sec_q <= frz_sec;
                disp_min_q <= frz_min;
            end else begin
                disp_cs_q  <= cnt_cs;
                disp_sec_q <= cnt_sec;
                disp_min_q <= cnt_min;
            end

            case (state)
                IDLE: begin
                    if (ev_ss) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (ev_ss) begin
                        state     <= PAUSED;
                        running_q <= 1'b0;
                    end else if (ev_lap) begin
                        // Snapshot the count as it stands before this edge.
                        state      <= LAP;
                        lap_hold_q <= 1'b1;
                        frz_cs     <= cnt_cs;
                        frz_sec    <= cnt_sec;
                        frz_min    <= cnt_min;
                    end
                end
                LAP: begin
                    if (ev_ss) begin
                        state      <= PAUSED;
                        running_q  <= 1'b0;
                        lap_hold_q <= 1'b0;
                    end else if (ev_lap) begin
                        state      <= RUN;
                        lap_hold_q <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (ev_clr) begin
                        state <= IDLE;
                    end else if (ev_ss) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running_q  <= 1'b0;
                    lap_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.running  = running_q;
    assign bus.lap_hold = lap_hold_q;
    assign bus.wrap     = wrap_q;
    assign bus.disp_cs  = disp_cs_q;
    assign bus.disp_sec = disp_sec_q;
    assign bus.disp_min = disp_min_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed scenarios then random keys/ticks,
// checked every cycle against a centisecond-integer model via a queue.
// Runs with MAX_MIN=1 so the full wrap fits in 12000 ticks.
module tb_stopwatch_controller;

    localparam int MAXM   = 1;
    localparam int PERIOD = (MAXM + 1) * 6000;

    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSED} mode_t;

    typedef struct packed {
        logic       running;
        logic       lap_hold;
        logic       wrap;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [7:0] cs;
    } obs_t;

    logic clock;
    logic resetn;

    stopwatch_controller_if bus();

    stopwatch_controller #(.MAX_MIN(MAXM)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    obs_t exp_q[$];

    // Reference model: the count is a plain number of centiseconds.
    mode_t m_mode   = M_IDLE;
    int    m_total  = 0;
    int    m_frozen = 0;
    bit    k_ss     = 1'b1;
    bit    k_lap    = 1'b1;
    bit    k_clr    = 1'b1;

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic obs_t make_obs(input bit run, input bit hold, input bit w, input int s);
        obs_t o;
        o.running  = run;
        o.lap_hold = hold;
        o.wrap     = w;
        o.mn       = bcd2(s / 6000);
        o.sc       = bcd2((s / 100) % 60);
        o.cs       = bcd2(s % 100);
        return o;
    endfunction

    // Drive one cycle of inputs (called at a falling edge), predict what the
    // outputs will be after the next rising edge, then wait one full cycle.
    task automatic step(input bit rst, input bit tk, input bit ss, input bit lp, input bit cl);
        bit    p_ss, p_lap, p_clr, w;
        int    shown;
        mode_t pre;
        resetn         = rst;
        bus.tick       = tk;
        bus.start_stop = ss;
        bus.lap        = lp;
        bus.clear      = cl;
        if (!rst) begin
            m_mode   = M_IDLE;
            m_total  = 0;
            m_frozen = 0;
            k_ss     = 1'b1;
            k_lap    = 1'b1;
            k_clr    = 1'b1;
            exp_q.push_back(make_obs(1'b0, 1'b0, 1'b0, 0));
        end else begin
            p_clr = cl & ~k_clr;
            p_ss  = ss & ~k_ss & ~p_clr;
            p_lap = lp & ~k_lap & ~p_clr & ~p_ss;
            k_ss  = ss;
            k_lap = lp;
            k_clr = cl;
            pre   = m_mode;
            shown = (pre == M_LAP) ? m_frozen : m_total;
            w     = 1'b0;
            case (pre)
                M_IDLE:   if (p_ss) m_mode = M_RUN;
                M_RUN:    if (p_ss) m_mode = M_PAUSED;
                          else if (p_lap) begin m_mode = M_LAP; m_frozen = m_total; end
                M_LAP:    if (p_ss) m_mode = M_PAUSED;
                          else if (p_lap) m_mode = M_RUN;
                M_PAUSED: if (p_clr) begin m_mode = M_IDLE; m_total = 0; end
                          else if (p_ss) m_mode = M_RUN;
                default:  m_mode = M_IDLE;
            endcase
            if (tk && (pre == M_RUN || pre == M_LAP)) begin
                m_total = m_total + 1;
                if (m_total == PERIOD) begin
                    m_total = 0;
                    w = 1'b1;
                end
            end
            exp_q.push_back(make_obs(m_mode == M_RUN || m_mode == M_LAP,
                                     m_mode == M_LAP, w, shown));
        end
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] disp_now();
        return {8'h00, bus.disp_min, bus.disp_sec, bus.disp_cs};
    endfunction

    // Monitor: after each rising edge compare outputs with the oldest prediction.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.running  = bus.running;
                a.lap_hold = bus.lap_hold;
                a.wrap     = bus.wrap;
                a.mn       = bus.disp_min;
                a.sc       = bus.disp_sec;
                a.cs       = bus.disp_cs;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL obs t=%0t got run=%b hold=%b wrap=%b %h:%h.%h want run=%b hold=%b wrap=%b %h:%h.%h",
                             $time, a.running, a.lap_hold, a.wrap, a.mn, a.sc, a.cs,
                             e.running, e.lap_hold, e.wrap, e.mn, e.sc, e.cs);
                end
            end
        end
    end

    initial begin
        bit rk_ss, rk_lap, rk_clr;
        resetn         = 1'b0;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b1;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
        @(negedge clock);

        // start_stop held through reset: not a press until released/re-pressed.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_running", {31'd0, bus.running}, 32'd0);
        chk("reset_hold", {31'd0, bus.lap_hold}, 32'd0);
        chk("reset_wrap", {31'd0, bus.wrap}, 32'd0);
        chk("reset_disp", disp_now(), 32'h000000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_key_no_start", {31'd0, bus.running}, 32'd0);
        idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("repress_running", {31'd0, bus.running}, 32'd1);

        // 150 ticks, then stop on the same cycle as tick 151.
        ticks(150);
        idle();
        chk("run150_disp", disp_now(), 32'h000150);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("stop_tick_counted", disp_now(), 32'h000151);
        chk("paused_running", {31'd0, bus.running}, 32'd0);
        ticks(20);
        chk("paused_no_count", disp_now(), 32'h000151);

        // Resume to 02.37, lap, 500 ticks frozen, release lap.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(86);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_hold_set", {31'd0, bus.lap_hold}, 32'd1);
        chk("lap_disp", disp_now(), 32'h000237);
        ticks(500);
        chk("lap_frozen", disp_now(), 32'h000237);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lap_release_disp", disp_now(), 32'h000737);
        chk("lap_release_hold", {31'd0, bus.lap_hold}, 32'd0);

        // Clear is ignored while running.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("clear_in_run_running", {31'd0, bus.running}, 32'd1);
        chk("clear_in_run_disp", disp_now(), 32'h000737);

        // Stop then clear alone -> IDLE.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("clear_paused_disp", disp_now(), 32'h000000);

        // Pause at 03.00, clear + start_stop together: clear wins.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(300);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("paused_300", disp_now(), 32'h000300);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("clr_ss_disp", disp_now(), 32'h000000);
        chk("clr_ss_running", {31'd0, bus.running}, 32'd0);

        // Full wrap at 01:59.99 + tick.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11999);
        chk("prewrap_wrap", {31'd0, bus.wrap}, 32'd0);
        ticks(1);
        chk("wrap_pulse", {31'd0, bus.wrap}, 32'd1);
        chk("wrap_disp_last", disp_now(), 32'h015999);
        idle();
        chk("wrap_one_cycle", {31'd0, bus.wrap}, 32'd0);
        chk("wrap_disp_zero", disp_now(), 32'h000000);
        chk("wrap_still_running", {31'd0, bus.running}, 32'd1);

        // LAP at 00:45.12, then a one-cycle reset with a pending press.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4512);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lap4512_disp", disp_now(), 32'h004512);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_running", {31'd0, bus.running}, 32'd0);
        chk("midreset_hold", {31'd0, bus.lap_hold}, 32'd0);
        chk("midreset_wrap", {31'd0, bus.wrap}, 32'd0);
        chk("midreset_disp", disp_now(), 32'h000000);
        idle();

        // Random phase: slowly toggling key levels, random ticks, rare resets.
        rk_ss  = 1'b0;
        rk_lap = 1'b0;
        rk_clr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rk_ss  = ~rk_ss;
            if ($urandom_range(0, 7) == 0) rk_lap = ~rk_lap;
            if ($urandom_range(0, 9) == 0) rk_clr = ~rk_clr;
            step($urandom_range(0, 399) != 0, $urandom_range(0, 1) == 1,
                 rk_ss, rk_lap, rk_clr);
        end

        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
